alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 opcode  input  7  instruction opcode.
REQ-007 funct3  input  3  instruction funct3.
REQ-008 funct7b5  input  1  instruction bit 30.
REQ-009 rs1_val, rs2_val, imm  input  32 each  operand values; imm is already sign-extended.
REQ-010 alu_ctrl  output  3  operation code driven to the ALU.
REQ-011 alu_a, alu_b  output  32 each  operands driven to the ALU.
REQ-012 alu_w  input  32  ALU result.
REQ-013 alu_zero, alu_neg  input  1 each  ALU flags.
REQ-014 out_valid  output  1  response present.
REQ-015 out_ready  input  1  consumer accepts the response.
REQ-016 out_result  output  32  captured ALU result.
REQ-017 out_taken  output  1  branch decision.
REQ-018 out_neg  output  1  captured alu_neg.
REQ-019 out_illegal  output  1  request was not decodable.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, EXEC and RESP; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in RESP.
REQ-021 A request SHALL be accepted in IDLE on the edge where in_valid=1; decoded ctrl, a and b SHALL be registered on that edge, and the state SHALL go to EXEC (or to RESP if illegal).
REQ-022 The ALU codes SHALL be: ADD=000, SUB=001, AND=010, OR=011, SLTU=100, SLT=101, XOR=110.
REQ-023 R-type (0110011) SHALL decode with a=rs1 and b=rs2 as follows.
- f3 000: SUB if funct7b5=1, otherwise ADD.
- f3 111: AND; f3 110: OR; f3 100: XOR; f3 010: SLT; f3 011: SLTU.
- f3 001 and f3 101: illegal.
REQ-024 I-type ALU (0010011) SHALL decode as R-type but with b=imm; f3 000 SHALL always be ADD, and f3 001 and f3 101 SHALL be illegal.
REQ-025 Load (0000011) and store (0100011) SHALL decode to ADD with a=rs1 and b=imm.
REQ-026 Branch (1100011) SHALL use a=rs1 and b=rs2, with the decision computed in EXEC as follows.
- BEQ/BNE (f3 000/001): SUB; taken=zero for BEQ, taken=~zero for BNE.
- BLT/BGE (f3 100/101): SLT; taken=~zero for BLT, taken=zero for BGE.
- BLTU/BGEU (f3 110/111): SLTU, with the same taken rule as BLT/BGE.
- f3 010/011: illegal.
REQ-027 Any other opcode SHALL be illegal.
REQ-028 For an illegal request, the block SHALL go IDLE->RESP directly with out_illegal=1, out_result=0, out_taken=0 and out_neg=0, and the ALU registers SHALL be left unchanged.
REQ-029 EXEC SHALL last exactly one cycle: alu_ctrl, alu_a and alu_b SHALL be driven from the registers, and alu_w, alu_neg and the taken decision SHALL be captured at the end of EXEC; the state SHALL then go to RESP.
REQ-030 out_taken SHALL be 0 for every non-branch request.
REQ-031 alu_ctrl, alu_a and alu_b SHALL be register outputs, stable in every state, and SHALL change only on acceptance.
REQ-032 In RESP, all out_* signals SHALL hold stable until out_ready=1; on that edge the state SHALL go to IDLE.
REQ-033 A new request SHALL NOT be accepted on the same edge as the RESP handshake, giving a minimum period of 3 cycles for a legal request and 2 cycles for an illegal one.
REQ-034 in_valid while not in IDLE SHALL be ignored, with no state change.
REQ-035 out_ready while not in RESP SHALL be ignored.
REQ-036 Latency for a legal request SHALL be exactly 2 edges from acceptance to out_valid=1; for an illegal request it SHALL be 1 edge.

Reset
REQ-037 While rst=0, the state SHALL be IDLE, and every register (alu_ctrl=000, alu_a=0, alu_b=0, out_result=0, out_taken=0, out_neg=0, out_illegal=0) SHALL be 0; out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-038 Reset asserted during EXEC or RESP SHALL abort the transaction immediately, with no response issued.
REQ-039 in_ready SHALL rise to 1 in the first cycle in which rst=1.

Verification
REQ-040 The bench SHALL cover R-type SUB (funct7b5=1, rs1=5, rs2=7) -> alu_ctrl=001, out_result=0xFFFFFFFE, out_neg=1, out_taken=0, and out_valid 2 edges after acceptance.
REQ-041 The bench SHALL cover BLTU (rs1=0xFFFFFFFF, rs2=1) -> alu_ctrl=100 and out_taken=0; with BLT on the same operands -> alu_ctrl=101 and out_taken=1.
REQ-042 The bench SHALL cover addi (imm=0xFFFFFFFC, rs1=4) -> alu_b=0xFFFFFFFC, out_result=0, out_taken=0.
REQ-043 The bench SHALL cover opcode 0110011 with f3=001 -> out_illegal=1, out_result=0, out_valid 1 edge after acceptance, and alu_* unchanged.
REQ-044 The bench SHALL cover out_ready held 0 for 5 cycles in RESP -> outputs stable and in_ready=0 throughout; then out_ready=1 -> IDLE on the next edge.
REQ-045 The bench SHALL cover rst pulsed low during EXEC -> out_valid never rises, and all outputs are 0 immediately.

Source files
------------

// File: rtl/alu_issue_unit.sv
// ALU issue unit: decodes one RV32I request, drives a registered ALU operand
// set for one cycle, then holds the captured result until the consumer takes it.
module alu_issue_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_w,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_taken,
    output logic        out_neg,
    output logic        out_illegal
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] C_ADD  = 3'b000;
    localparam logic [2:0] C_SUB  = 3'b001;
    localparam logic [2:0] C_AND  = 3'b010;
    localparam logic [2:0] C_OR   = 3'b011;
    localparam logic [2:0] C_SLTU = 3'b100;
    localparam logic [2:0] C_SLT  = 3'b101;
    localparam logic [2:0] C_XOR  = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [2:0] d_ctrl;
    logic       d_imm;
    logic       d_ill;
    logic       d_br;
    logic       d_inv;
    logic       br_q;
    logic       inv_q;

    logic is_r, is_i, is_mem, is_br;
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_br  = (opcode == OP_BR);

    // Branch taken = zero flag, inverted for BNE, BLT and BLTU.
    assign d_inv = funct3[2] ? ~funct3[0] : funct3[0];

    always_comb begin
        d_ctrl = C_ADD;
        d_imm  = 1'b0;
        d_ill  = 1'b0;
        d_br   = 1'b0;
        unique case (1'b1)
            is_r, is_i: begin
                d_imm = is_i;
                unique case (funct3)
                    3'b000:  d_ctrl = (is_r && funct7b5) ? C_SUB : C_ADD;
                    3'b111:  d_ctrl = C_AND;
                    3'b110:  d_ctrl = C_OR;
                    3'b100:  d_ctrl = C_XOR;
                    3'b010:  d_ctrl = C_SLT;
                    3'b011:  d_ctrl = C_SLTU;
                    default: d_ill  = 1'b1;
                endcase
            end
            is_mem: d_imm = 1'b1;
            is_br: begin
                d_br = 1'b1;
                unique case (funct3[2:1])
                    2'b00:   d_ctrl = C_SUB;
                    2'b10:   d_ctrl = C_SLT;
                    2'b11:   d_ctrl = C_SLTU;
                    default: d_ill  = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign in_ready  = rst && (state == IDLE);
    assign out_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            alu_ctrl    <= C_ADD;
            alu_a       <= '0;
            alu_b       <= '0;
            br_q        <= 1'b0;
            inv_q       <= 1'b0;
            out_result  <= '0;
            out_taken   <= 1'b0;
            out_neg     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (d_ill) begin
                            out_illegal <= 1'b1;
                            out_result  <= '0;
                            out_taken   <= 1'b0;
                            out_neg     <= 1'b0;
                            state       <= RESP;
                        end else begin
                            alu_ctrl <= d_ctrl;
                            alu_a    <= rs1_val;
                            alu_b    <= d_imm ? imm : rs2_val;
                            br_q     <= d_br;
                            inv_q    <= d_inv;
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    out_result  <= alu_w;
                    out_neg     <= alu_neg;
                    out_taken   <= br_q & (alu_zero ^ inv_q);
                    out_illegal <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: acts as the ALU, drives directed and random
// requests, and compares every response against a transaction-level model.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] imm = '0;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_w;
    logic        alu_zero;
    logic        alu_neg;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_taken;
    logic        out_neg;
    logic        out_illegal;

    alu_issue_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_taken(out_taken),
        .out_neg(out_neg), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    // Model of the operand registers the ALU should currently see.
    logic [2:0]  m_ctrl = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    // Values observed in the most recent response.
    int          seen_lat;
    logic [2:0]  seen_ctrl;
    logic [31:0] seen_a, seen_b, seen_res;
    logic        seen_taken, seen_neg, seen_ill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return {31'd0, a < b};
            3'b101:  return {31'd0, $signed(a) < $signed(b)};
            3'b110:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic decode_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              output logic [2:0] c, output logic use_imm,
                              output logic ill, output logic br);
        logic [2:0] tab [8];
        tab = '{3'b000, 3'b000, 3'b101, 3'b100, 3'b110, 3'b000, 3'b011, 3'b010};
        c = 3'b000; use_imm = 1'b0; ill = 1'b0; br = 1'b0;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            use_imm = (op == 7'b0010011);
            ill = (f3 == 3'd1) || (f3 == 3'd5);
            c = tab[f3];
            if (f3 == 3'd0 && !use_imm && f7) c = 3'b001;
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            use_imm = 1'b1;
        end else if (op == 7'b1100011) begin
            br = 1'b1;
            ill = (f3 == 3'd2) || (f3 == 3'd3);
            c = (f3 < 3'd4) ? 3'b001 : (f3 < 3'd6) ? 3'b101 : 3'b100;
        end else begin
            ill = 1'b1;
        end
    endtask

    always_comb begin
        alu_w    = alu_ref(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_w == 32'd0);
        alu_neg  = alu_w[31];
    end

    // Continuous check: ALU operand registers and handshake exclusivity.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, m_ctrl});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("ready_valid_excl", {31'd0, in_ready & out_valid}, 32'd0);
        end
    end

    task automatic scramble();
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        opcode    = 7'($urandom);
        funct3    = 3'($urandom);
        rs1_val   = $urandom;
        rs2_val   = $urandom;
        imm       = $urandom;
    endtask

    task automatic run_req(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input int hold);
        logic [2:0]  ec;
        logic        ui, ill, br, et, en;
        logic [31:0] er;
        int          lat;
        decode_ref(op, f3, f7, ec, ui, ill, br);
        opcode = op; funct3 = f3; funct7b5 = f7;
        rs1_val = r1; rs2_val = r2; imm = im;
        in_valid = 1'b1; out_ready = 1'($urandom);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        if (!ill) begin
            m_ctrl = ec; m_a = r1; m_b = ui ? im : r2;
        end
        er = ill ? 32'd0 : alu_ref(ec, r1, ui ? im : r2);
        en = er[31];
        et = (br && !ill) ? br_ref(f3, r1, r2) : 1'b0;
        scramble();
        lat = 1;
        while (!out_valid && lat < 6) begin
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
            scramble();
        end
        out_ready = 1'b0;
        chk("latency", lat, ill ? 32'd1 : 32'd2);
        chk("out_result", out_result, er);
        chk("out_flags", {29'd0, out_illegal, out_taken, out_neg}, {29'd0, ill, et, en});
        chk("in_ready_resp", {31'd0, in_ready}, 32'd0);
        seen_lat = lat; seen_ctrl = alu_ctrl; seen_a = alu_a; seen_b = alu_b;
        seen_res = out_result; seen_taken = out_taken;
        seen_neg = out_neg; seen_ill = out_illegal;
        repeat (hold) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            chk("hold_result", out_result, er);
            chk("hold_state", {27'd0, out_valid, in_ready, out_illegal, out_taken, out_neg},
                {27'd0, 1'b1, 1'b0, ill, et, en});
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("handshake_idle", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom % 4)
            0:       return 32'($urandom % 4);
            1:       return 32'hFFFF_FFFF - 32'($urandom % 4);
            2:       return 32'h8000_0000 + 32'($urandom % 4);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [6:0]  ops [6];
        logic [6:0]  op;
        logic [31:0] r1, r2;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu", {29'd0, alu_ctrl} | alu_a | alu_b, 32'd0);
        chk("rst_outs", out_result | {29'd0, out_taken, out_neg, out_illegal}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", {31'd0, in_ready}, 32'd1);
        cmp_on = 1'b1;

        run_req(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 0);
        chk("sub_ctrl", {29'd0, seen_ctrl}, 32'd1);
        chk("sub_result", seen_res, 32'hFFFF_FFFE);
        chk("sub_neg_taken", {30'd0, seen_neg, seen_taken}, 32'd2);
        chk("sub_latency", seen_lat, 32'd2);

        run_req(7'b1100011, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        chk("bltu_ctrl", {29'd0, seen_ctrl}, 32'd4);
        chk("bltu_taken", {31'd0, seen_taken}, 32'd0);
        run_req(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        chk("blt_ctrl", {29'd0, seen_ctrl}, 32'd5);
        chk("blt_taken", {31'd0, seen_taken}, 32'd1);

        run_req(7'b0010011, 3'b000, 1'b1, 32'd4, 32'd99, 32'hFFFF_FFFC, 0);
        chk("addi_b", seen_b, 32'hFFFF_FFFC);
        chk("addi_result", seen_res, 32'd0);
        chk("addi_taken", {31'd0, seen_taken}, 32'd0);

        run_req(7'b0110011, 3'b001, 1'b0, 32'd123, 32'd456, 32'd0, 0);
        chk("ill_flag", {31'd0, seen_ill}, 32'd1);
        chk("ill_result", seen_res, 32'd0);
        chk("ill_latency", seen_lat, 32'd1);
        chk("ill_alu_kept", {29'd0, seen_ctrl} ^ seen_a ^ seen_b, 32'd4 ^ 32'hFFFF_FFFC);

        run_req(7'b0110011, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 5);
        chk("and_result", seen_res, 32'h0F00_0F00);

        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        rs1_val = 32'd1; rs2_val = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        m_ctrl = '0; m_a = '0; m_b = '0;
        #1;
        chk("abort_alu", {29'd0, alu_ctrl} | alu_a | alu_b, 32'd0);
        chk("abort_outs", out_result | {27'd0, out_valid, in_ready, out_taken, out_neg, out_illegal}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle", {30'd0, out_valid, in_ready}, 32'd1);
        end
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom % 6];
            if (op == 7'b0000000) op = 7'($urandom);
            r1 = rnd_val();
            r2 = ($urandom % 4 == 0) ? r1 : rnd_val();
            run_req(op, 3'($urandom), 1'($urandom), r1, r2, rnd_val(), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
